vga_text_renderer: RTL and testbench
====================================

Name: vga_text_renderer

Overview:
- Text-mode pixel pipeline that drives the font ROM lookup (ascii_code/row/col in, 1-bit pixel out, 1-clock read latency) and consumes its pixel result.
- Takes raster counters and syncs from the VGA timing generator, fetches the character code from the text buffer RAM, addresses the font ROM and produces registered RGB plus delayed syncs.
- Sits between VGA timing and the DAC/output pins.

Parameters:
- COLS, 80, characters per text row.
- ROWS, 30, text rows per screen.
- ADDR_W, 12, text buffer address width.
- FG_COLOR, 12'hFFF, RGB444 colour for set pixels.
- BG_COLOR, 12'h000, RGB444 colour for clear pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-low reset.
- h_cnt  in  10  horizontal pixel counter.
- v_cnt  in  10  vertical line counter.
- de_in  in  1  display enable, high in the visible area.
- hsync_in  in  1  hsync, active-low.
- vsync_in  in  1  vsync, active-low.
- char_addr  out  ADDR_W  text buffer read address.
- char_data  in  8  text buffer data, valid 1 clock after char_addr; [7]=inverse, [6:0]=ASCII.
- ascii_code  out  7  font ROM character select.
- font_row  out  4  font ROM glyph row.
- font_col  out  3  font ROM glyph column.
- font_pixel  in  1  font ROM pixel, valid 1 clock after the font address.
- cursor_x  in  7  cursor column.
- cursor_y  in  5  cursor row.
- rgb_out  out  12  RGB444 pixel.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- de_out  out  1  delayed display enable.

Behaviour:
- Cell decode, combinational from the inputs:
  - col_idx = h_cnt[9:3], row_idx = v_cnt[9:4].
  - cell_valid = de_in & (col_idx < COLS) & (row_idx < ROWS).
- Stage 0 (combinational):
  - char_addr = cell_valid ? row_idx*COLS + col_idx : 0, truncated to ADDR_W. The constant multiply may be built as shift-add.
- Stage 1 (registered at edge 1):
  - Register v_cnt[3:0]→font_row and h_cnt[2:0]→font_col.
  - Register cell_valid, de_in, hsync_in, vsync_in and the cursor-hit flag.
  - ascii_code = char_data[6:0], combinational from RAM output; inv1 = char_data[7].
- Stage 2 (registered at edge 2):
  - Register inv1, valid, de, syncs and cursor flag alongside the font ROM access.
- Stage 3 (registered at edge 3):
  - on = font_pixel ^ inv2 ^ cur2.
  - rgb_out = (de2 & valid2) ? (on ? FG_COLOR : BG_COLOR) : 12'h000.
  - hsync_out, vsync_out and de_out take their stage-2 copies.
- Latency: exactly 3 clocks from inputs to rgb_out/hsync_out/vsync_out/de_out, with all four aligned.
- No stalls and no backpressure: one pixel per clock, continuously.
- Reset, while rst=0 at an edge:
  - rgb_out=0, de_out=0, hsync_out=1, vsync_out=1.
  - All pipeline valid/de bits cleared, syncs set to 1, font_row=0, font_col=0, frame counter cleared.
  - Reset mid-frame: output is blank until real data has refilled 3 stages after release.
- Blanking (de_in=0 or col/row out of range): rgb_out=0 regardless of font_pixel or inverse.
- Wrap: h_cnt/v_cnt beyond the text area produce no out-of-range char_addr, because the address is forced to 0.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- Defined:
  - Cursor hit = cell_valid & col_idx==cursor_x & row_idx==cursor_y & v_cnt[3:0]>=14.
  - A 5-bit frame counter increments on each vsync_in 1→0 transition, tracked by a registered previous-vsync bit; it wraps 31→0.
  - The cursor flag is the hit AND (frame_cnt[4]==0), i.e. 16 frames on, 16 off.
- Not defined: cursor_x/cursor_y are ignored, the cursor flag is constant 0 and no frame counter is synthesised.

Test Plan:
- Reset: hold rst=0 for 2 clocks with random inputs → rgb_out=0, de_out=0, hsync_out=1, vsync_out=1; stays blank for 3 clocks after release.
- Address decode: h_cnt=17, v_cnt=35, de_in=1 → char_addr=162 (2*80+2) the same cycle; font_row=3, font_col=1 one clock later.
- Glyph render: behavioural RAM returns 0x41 at addr 0; font model returns the 'A' bitmap; sweep h_cnt=0..7 at v_cnt=5 → rgb_out shows 'A' row 5 (FFF/000 per bit) exactly 3 clocks later, aligned with de_out and hsync_out.
- Inverse and blank:
  - char_data=0xC1 → colours swapped relative to 0x41.
  - de_in=0 with font_pixel=1 → rgb_out=0.
  - h_cnt=640 (col_idx=80) with de_in=1 → rgb_out=0, char_addr=0.
- Cursor (TEXT_CURSOR_EN): cursor_x=5, cursor_y=2, space char at v_cnt=46..47, h_cnt=40..47 → rgb_out=FFF for frame_cnt 0–15, 000 for 16–31, counter wrapping after 32 vsync falls. Without the macro → always 000.

Source files
------------

// File: rtl/vga_text_renderer_if.sv
// Signal bundle between the text renderer, its raster source, text RAM, font ROM and output pins.
// master = renderer side, slave = environment side.
interface vga_text_renderer_if #(
  parameter int ADDR_W = 12
);
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              de_in;
  logic              hsync_in;
  logic              vsync_in;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic [6:0]        ascii_code;
  logic [3:0]        font_row;
  logic [2:0]        font_col;
  logic              font_pixel;
  logic [6:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic [11:0]       rgb_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              de_out;

  modport master (
    input  h_cnt, v_cnt, de_in, hsync_in, vsync_in, char_data, font_pixel, cursor_x, cursor_y,
    output char_addr, ascii_code, font_row, font_col, rgb_out, hsync_out, vsync_out, de_out
  );

  modport slave (
    output h_cnt, v_cnt, de_in, hsync_in, vsync_in, char_data, font_pixel, cursor_x, cursor_y,
    input  char_addr, ascii_code, font_row, font_col, rgb_out, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline (text RAM -> font ROM -> RGB444); blinking cursor under TEXT_CURSOR_EN.
// Latency: 3 clocks from raster inputs to rgb_out/hsync_out/vsync_out/de_out, all aligned.
// No backpressure: accepts and emits one pixel every clock.
module vga_text_renderer #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 30,
  parameter int          ADDR_W   = 12,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input logic                 clk,
  input logic                 rst,
  vga_text_renderer_if.master bus
);
  logic [6:0]        col_idx;
  logic [5:0]        row_idx;
  logic              cell_valid;
  logic [ADDR_W-1:0] cell_addr;
  logic              cur_hit;

  assign col_idx    = bus.h_cnt[9:3];
  assign row_idx    = bus.v_cnt[9:4];
  assign cell_valid = bus.de_in & (32'(col_idx) < 32'(COLS)) & (32'(row_idx) < 32'(ROWS));
  assign cell_addr  = ADDR_W'(row_idx) * ADDR_W'(COLS) + ADDR_W'(col_idx);
  // Off-screen counters must never reach the RAM with a wrapped address.
  assign bus.char_addr = cell_valid ? cell_addr : '0;

`ifdef TEXT_CURSOR_EN
  logic [4:0] frame_cnt;
  logic       vs_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
      vs_prev   <= 1'b1;
    end else begin
      vs_prev <= bus.vsync_in;
      if (vs_prev & ~bus.vsync_in)
        frame_cnt <= frame_cnt + 5'd1;
    end
  end

  // Underline cursor on the bottom two glyph rows, visible for 16 of every 32 frames.
  assign cur_hit = cell_valid & (col_idx == bus.cursor_x) & (row_idx == {1'b0, bus.cursor_y})
                 & (bus.v_cnt[3:0] >= 4'd14) & ~frame_cnt[4];
`else
  assign cur_hit = 1'b0;
`endif

  logic [3:0]  font_row_q;
  logic [2:0]  font_col_q;
  logic        valid1, de1, hs1, vs1, cur1;
  logic        inv2, valid2, de2, hs2, vs2, cur2;
  logic [11:0] rgb_q;
  logic        hs_q, vs_q, de_q;
  logic        pix_on;

  assign bus.ascii_code = bus.char_data[6:0];
  assign bus.font_row   = font_row_q;
  assign bus.font_col   = font_col_q;
  assign pix_on         = bus.font_pixel ^ inv2 ^ cur2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      font_row_q <= '0;
      font_col_q <= '0;
      valid1     <= 1'b0;
      de1        <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      cur1       <= 1'b0;
      inv2       <= 1'b0;
      valid2     <= 1'b0;
      de2        <= 1'b0;
      hs2        <= 1'b1;
      vs2        <= 1'b1;
      cur2       <= 1'b0;
      rgb_q      <= 12'h000;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
    end else begin
      // Stage 1: RAM read in flight, glyph coordinates captured.
      font_row_q <= bus.v_cnt[3:0];
      font_col_q <= bus.h_cnt[2:0];
      valid1     <= cell_valid;
      de1        <= bus.de_in;
      hs1        <= bus.hsync_in;
      vs1        <= bus.vsync_in;
      cur1       <= cur_hit;
      // Stage 2: font ROM read in flight.
      inv2       <= bus.char_data[7];
      valid2     <= valid1;
      de2        <= de1;
      hs2        <= hs1;
      vs2        <= vs1;
      cur2       <= cur1;
      // Stage 3: colour resolve.
      rgb_q      <= (de2 & valid2) ? (pix_on ? FG_COLOR : BG_COLOR) : 12'h000;
      hs_q       <= hs2;
      vs_q       <= vs2;
      de_q       <= de2;
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.hsync_out = hs_q;
  assign bus.vsync_out = vs_q;
  assign bus.de_out    = de_q;
endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: address table, glyph/inverse/blank/cursor sequences, and randomized
// raster traffic checked every clock against a cell/glyph arithmetic reference model.
module tb_vga_text_renderer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef TEXT_CURSOR_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  vga_text_renderer_if #(.ADDR_W(12)) bus ();

  vga_text_renderer #(
    .COLS(80), .ROWS(30), .ADDR_W(12), .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  text_mem [4096];
  logic [7:0]  a_font [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                               8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [11:0] a_row5 [8] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000};

  int passed = 0;
  int total  = 0;

  function automatic logic [7:0] glyph(input logic [6:0] a, input logic [3:0] r);
    if (a == 7'h41) return a_font[r];
    if (a == 7'h20) return 8'h00;
    return ({1'b0, a} * 8'd13) ^ {r, r};
  endfunction

  function automatic logic font_px(input logic [6:0] a, input logic [3:0] r, input logic [2:0] c);
    logic [7:0] g;
    g = glyph(a, r);
    return g[3'd7 - c];
  endfunction

  // Environment: text RAM and font ROM, each with one clock of read latency.
  always @(posedge clk) begin
    bus.char_data  <= text_mem[bus.char_addr];
    bus.font_pixel <= font_px(bus.ascii_code, bus.font_row, bus.font_col);
  end

  // Reference: what the screen shows for one raster position, returned as {rgb, de, hsync, vsync}.
  function automatic logic [14:0] model_out(input logic [9:0] h, input logic [9:0] v, input logic de,
                                            input logic hs, input logic vs, input logic [6:0] cx,
                                            input logic [4:0] cy, input int frames);
    int         col, row;
    logic [7:0] ch;
    logic       on;
    logic [11:0] rgb;
    col = int'(h) / 8;
    row = int'(v) / 16;
    rgb = 12'h000;
    if (de && col < 80 && row < 30) begin
      ch = text_mem[row * 80 + col];
      on = font_px(ch[6:0], v[3:0], h[2:0]) ^ ch[7];
      if (CURSOR_ON && col == int'(cx) && row == int'(cy) && v[3:0] >= 4'd14 && frames < 16)
        on = ~on;
      rgb = on ? 12'hFFF : 12'h000;
    end
    return {rgb, de, hs, vs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [14:0] get_out();
    return {bus.rgb_out, bus.de_out, bus.hsync_out, bus.vsync_out};
  endfunction

  task automatic drive(input int h, input int v, input logic de, input logic hs, input logic vs);
    bus.h_cnt    = 10'(h);
    bus.v_cnt    = 10'(v);
    bus.de_in    = de;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
  endtask

  // Per-edge history: reset level and modelled output for the pixel captured at that edge.
  int          n = 0;
  int          frames = 0;
  logic        prev_vs = 1'b1;
  logic        h_rst [8];
  logic [14:0] h_exp [8];

  task automatic cycle();
    logic        blank;
    logic [14:0] exp;
    @(posedge clk);
    n++;
    h_rst[n % 8] = rst;
    if (!rst) begin
      frames  = 0;
      prev_vs = 1'b1;
      h_exp[n % 8] = 15'h3;
    end else begin
      h_exp[n % 8] = model_out(bus.h_cnt, bus.v_cnt, bus.de_in, bus.hsync_in, bus.vsync_in,
                               bus.cursor_x, bus.cursor_y, frames);
      if (prev_vs && !bus.vsync_in) frames = (frames + 1) % 32;
      prev_vs = bus.vsync_in;
    end
    @(negedge clk);
    if (n >= 3) begin
      blank = !h_rst[n % 8] || !h_rst[(n - 1) % 8] || !h_rst[(n - 2) % 8];
      exp   = blank ? 15'h3 : h_exp[(n - 2) % 8];
      chk("pipeline_model", 32'(get_out()), 32'(exp));
    end
  endtask

  task automatic sweep_a(input logic inverse);
    logic [11:0] exp_rgb;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(k, 5, 1'b1, (k != 3), 1'b1);
      else       drive(0, 5, 1'b0, 1'b1, 1'b1);
      cycle();
      if (k >= 2) begin
        exp_rgb = a_row5[k - 2] ^ (inverse ? 12'hFFF : 12'h000);
        chk("glyph_rgb", 32'(bus.rgb_out), 32'(exp_rgb));
        chk("glyph_de", 32'(bus.de_out), 32'd1);
        chk("glyph_hsync", 32'(bus.hsync_out), 32'(k - 2 != 3));
      end
    end
  endtask

  typedef struct {
    int         h;
    int         v;
    logic       de;
    logic [11:0] addr;
    logic [3:0] row;
    logic [2:0] col;
  } addr_vec_t;

  addr_vec_t av [9];

  initial begin
    int h, v;
    logic [11:0] exp_c;
    av[0] = '{17,   35,   1'b1, 12'd162,  4'd3,  3'd1};
    av[1] = '{0,    0,    1'b1, 12'd0,    4'd0,  3'd0};
    av[2] = '{639,  479,  1'b1, 12'd2399, 4'd15, 3'd7};
    av[3] = '{640,  35,   1'b1, 12'd0,    4'd3,  3'd0};
    av[4] = '{17,   35,   1'b0, 12'd0,    4'd3,  3'd1};
    av[5] = '{8,    16,   1'b1, 12'd81,   4'd0,  3'd0};
    av[6] = '{100,  480,  1'b1, 12'd0,    4'd0,  3'd4};
    av[7] = '{1023, 1023, 1'b1, 12'd0,    4'd15, 3'd7};
    av[8] = '{327,  250,  1'b1, 12'd1240, 4'd10, 3'd7};

    for (int i = 0; i < 4096; i++) text_mem[i] = 8'h20;
    for (int i = 0; i < 8; i++) begin
      h_rst[i] = 1'b0;
      h_exp[i] = 15'h3;
    end
    bus.cursor_x = 7'd5;
    bus.cursor_y = 5'd2;

    // Reset with live random inputs, then release and watch the pipeline refill.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      chk("reset_out", 32'(get_out()), 32'h3);
    end
    rst = 1'b1;
    drive(0, 0, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("release_blank1", 32'(get_out()), 32'h3);
    cycle();
    chk("release_blank2", 32'(get_out()), 32'h3);
    cycle();
    chk("release_refill_de", 32'(bus.de_out), 32'd1);

    // Address decode and glyph coordinate registration.
    for (int i = 0; i < 9; i++) begin
      drive(av[i].h, av[i].v, av[i].de, 1'b1, 1'b1);
      #1;
      chk("char_addr", 32'(bus.char_addr), 32'(av[i].addr));
      cycle();
      chk("font_row", 32'(bus.font_row), 32'(av[i].row));
      chk("font_col", 32'(bus.font_col), 32'(av[i].col));
    end

    // 'A' row 5, normal then inverse.
    text_mem[0] = 8'h41;
    sweep_a(1'b0);
    text_mem[0] = 8'hC1;
    sweep_a(1'b1);

    // Blanking beats a set glyph pixel.
    text_mem[0] = 8'h41;
    drive(0, 5, 1'b0, 1'b1, 1'b1);
    cycle(); cycle(); cycle();
    chk("blank_de0_rgb", 32'(bus.rgb_out), 32'h0);
    drive(640, 5, 1'b1, 1'b1, 1'b1);
    #1;
    chk("oob_addr", 32'(bus.char_addr), 32'h0);
    cycle(); cycle(); cycle();
    chk("oob_rgb", 32'(bus.rgb_out), 32'h0);
    chk("oob_de", 32'(bus.de_out), 32'd1);

    // Cursor blink across 34 vsync falls after a fresh reset.
    rst = 1'b0;
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("reset2_out", 32'(get_out()), 32'h3);
    rst = 1'b1;
    text_mem[165] = 8'h20;
    for (int f = 0; f < 34; f++) begin
      drive(40 + f % 8, 46 + f % 2, 1'b1, 1'b1, 1'b1);
      cycle();
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      cycle(); cycle();
      exp_c = (CURSOR_ON && (f % 32) < 16) ? 12'hFFF : 12'h000;
      chk("cursor_blink", 32'(bus.rgb_out), 32'(exp_c));
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      cycle();
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      cycle();
    end
    drive(40, 45, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    cycle(); cycle();
    chk("cursor_row13_off", 32'(bus.rgb_out), 32'h0);

    // Randomized raster traffic with occasional mid-frame resets.
    for (int i = 0; i < 2400; i++) text_mem[i] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        bus.cursor_x = 7'($urandom_range(0, 79));
        bus.cursor_y = 5'($urandom_range(0, 29));
      end
      rst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        h = int'(bus.cursor_x) * 8 + int'($urandom_range(0, 7));
        v = int'(bus.cursor_y) * 16 + int'($urandom_range(12, 15));
      end else begin
        h = int'($urandom_range(0, 799));
        v = int'($urandom_range(0, 524));
      end
      drive(h, v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) != 0));
      cycle();
    end
    rst = 1'b1;
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
